// File: rtl/spi_pkg.sv
// Shared definitions for the SPI blocks: FSM state encoding, the default
// word width and the SPI mode constants (this master implements mode 0).
// Optional build macro used by the SPI blocks: SPI_LSB_FIRST_EN.
package spi_pkg;

    localparam int DEFAULT_N = 8;

    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_shreg.sv
// Parameterized n-bit shift register with parallel load, shift enable and
// serial in/out. Default order is MSB first; with SPI_LSB_FIRST_EN defined
// the LSB leaves first and new bits enter at the MSB side.
module spi_shreg #(
    parameter int n = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [n-1:0] load_data_i,
    input  logic         shift_i,
    input  logic         sin_i,
    output logic [n-1:0] data_o,
    output logic         sout_o
);

    // Load has priority over shift; the shift direction follows the bit order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o <= '0;
        end else if (load_i) begin
            data_o <= load_data_i;
        end else if (shift_i) begin
`ifdef SPI_LSB_FIRST_EN
            data_o <= {sin_i, data_o[n-1:1]};
`else
            data_o <= {data_o[n-2:0], sin_i};
`endif
        end
    end

`ifdef SPI_LSB_FIRST_EN
    assign sout_o = data_o[0];
`else
    assign sout_o = data_o[n-1];
`endif

endmodule

// File: rtl/spi_master.sv
// SPI master, mode 0. Timing comes from an external half-period tick (the
// clk_div slow_clk_o pulse). Build macro SPI_LSB_FIRST_EN selects LSB-first
// shifting in both directions; the default is MSB first.
module spi_master
    import spi_pkg::*;
#(
    parameter int n = DEFAULT_N
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         tick_i,
    input  logic         start_i,
    input  logic [n-1:0] data_i,
    input  logic         miso_i,
    output logic         sclk_o,
    output logic         mosi_o,
    output logic         cs_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [n-1:0] data_o
);

    localparam int CNT_W = $clog2(2 * n + 1);
    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * n - 1);

    spi_state_e state_q, state_d;
    logic [CNT_W-1:0] edge_cnt_q;
    logic sclk_q;
    logic accept, xfer_tick, trail_go;
    logic last_edge, rise_edge, fall_edge;
    logic [n-1:0] rx_q;
    logic [n-1:0] tx_par_unused;
    logic rx_ser_unused;

    assign last_edge = (edge_cnt_q == LAST_EDGE);
    assign rise_edge = xfer_tick & ~sclk_q;
    assign fall_edge = xfer_tick & sclk_q;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the per-cycle strobes that drive the datapath.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        xfer_tick = 1'b0;
        trail_go  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    accept  = 1'b1;
                    state_d = LEAD;
                end
            end
            LEAD: begin
                if (tick_i) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (tick_i) begin
                    xfer_tick = 1'b1;
                    if (last_edge) begin
                        state_d = TRAIL;
                    end
                end
            end
            TRAIL: begin
                if (tick_i) begin
                    trail_go = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // SCLK toggles on every transfer tick; the last tick forces it back low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_q     <= SPI_CPOL;
            edge_cnt_q <= '0;
        end else if (xfer_tick) begin
            if (last_edge) begin
                sclk_q     <= SPI_CPOL;
                edge_cnt_q <= '0;
            end else begin
                sclk_q     <= ~sclk_q;
                edge_cnt_q <= edge_cnt_q + 1'b1;
            end
        end
    end

    // Received word is published together with the one-cycle done pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_o <= 1'b0;
            data_o <= '0;
        end else begin
            done_o <= trail_go;
            if (trail_go) begin
                data_o <= rx_q;
            end
        end
    end

    // Transmit register: the final falling edge does not shift, so MOSI
    // keeps the last bit until the next acceptance.
    spi_shreg #(.n(n)) u_tx (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (accept),
        .load_data_i (data_i),
        .shift_i     (fall_edge & ~last_edge),
        .sin_i       (1'b0),
        .data_o      (tx_par_unused),
        .sout_o      (mosi_o)
    );

    // Receive register: cleared at acceptance, samples MISO as SCLK rises.
    spi_shreg #(.n(n)) u_rx (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (accept),
        .load_data_i ('0),
        .shift_i     (rise_edge),
        .sin_i       (miso_i),
        .data_o      (rx_q),
        .sout_o      (rx_ser_unused)
    );

    assign sclk_o = sclk_q;
    assign busy_o = (state_q != IDLE);
    assign cs_o   = (state_q == IDLE);

endmodule

// File: doc/spi_master.md
# spi_master

SPI master (mode 0: CPOL=0, CPHA=0) that serializes one n-bit word per transaction on MOSI and simultaneously captures n bits from MISO. It consumes the single-cycle `slow_clk_o` tick produced by the project's `clk_div` counter as its half-period timing enable, so the SCLK rate is set entirely by the divider's `kmax_i`. It sits between that divider and the external SPI slave, and provides a start/busy/done handshake to the controlling logic.

## Interface
- `n`, default 8: transaction word width in bits (≥2).
- `clk_i` input 1: system clock; all state updates on rising edge.
- `rst_i` input 1: asynchronous, active-high reset.
- `tick_i` input 1: half-period enable, wired to `clk_div.slow_clk_o`; one clk_i cycle wide per tick.
- `start_i` input 1: transaction request, sampled each cycle in IDLE.
- `data_i` input n: word to transmit, latched on start acceptance.
- `miso_i` input 1: serial data from slave.
- `sclk_o` output 1: SPI clock, idles low.
- `mosi_o` output 1: serial data to slave.
- `cs_o` output 1: chip select, active low.
- `busy_o` output 1: high whenever state ≠ IDLE.
- `done_o` output 1: one-cycle pulse, transaction complete.
- `data_o` output n: received word, updated when `done_o` rises, held until the next completion.

## Operation
- Reset values: `sclk_o`=0, `mosi_o`=0, `cs_o`=1, `busy_o`=0, `done_o`=0, `data_o`=0, state IDLE, all counters 0.
- The FSM has the states IDLE, LEAD, XFER and TRAIL.
- IDLE: if `start_i`=1, latch `data_i` into the tx shift register, clear the rx register, drive `cs_o`=0 and `mosi_o`=first bit, then go to LEAD. `tick_i` is ignored in IDLE.
- LEAD: CS setup; on `tick_i`, go to XFER. No SCLK edge is produced.
- XFER: each `tick_i` toggles `sclk_o`; the edge counter counts 2n ticks.
  - Rising SCLK edge (0→1): sample `miso_i` into the rx register.
  - Falling SCLK edge (1→0): advance the tx register and drive the next bit on `mosi_o`. The final falling edge does not change `mosi_o`.
  - After the 2n-th tick, `sclk_o`=0; go to TRAIL.
- TRAIL: CS hold; on `tick_i`, go to IDLE. In the same update: `cs_o`=1, `data_o`=rx register, `done_o`=1 for exactly one cycle.
- Default bit order is MSB first.
- `start_i` while `busy_o`=1 is ignored and has no side effects. `data_i` is don't-care after acceptance.
- Back-to-back transfers: `start_i` high in the cycle where `done_o`=1 is accepted. `cs_o` is then high for exactly one clk_i cycle between words.
- `tick_i` held constantly high (divider with `kmax_i`=0) is legal: half-period = 1 clk_i cycle.
- Reset asserted mid-transaction aborts immediately and asynchronously: `cs_o`=1, `sclk_o`=0, `done_o` is not pulsed, and `data_o` returns to 0.

## Timing
- Start accepted at the edge ending cycle T0. Then `cs_o`=0 and `busy_o`=1 from cycle T0+1.
- With one tick every P clk_i cycles:
  - The transaction takes (2n+2) ticks after acceptance.
  - For `tick_i`≡1 and n=8: `cs_o` is low on cycles T1..T18; `done_o`=1 and `cs_o`=1 on cycle T19.
- SCLK half-period = P cycles.
- MOSI changes only on SCLK falling edges, or at acceptance. MISO is sampled on the same clk_i edge that raises SCLK.
- Counter width: edge counter ⌈log2(2n+1)⌉ bits. It must not wrap before the 2n-th tick.

## Configuration
- `SPI_LSB_FIRST_EN` defined: the word is shifted out LSB first, and received bits are shifted in from the MSB side, so `data_o[0]` is the first bit received.
- Macro not defined: MSB first in both directions.
- Handshake and timing are identical in both builds.

## Structure
- Shared package `spi_pkg` holds:
  - the state encoding constants (IDLE=0, LEAD=1, XFER=2, TRAIL=3);
  - the default width;
  - the SPI mode constants, for reuse by a future slave block and the bench.
- One natural sub-module: `spi_shreg`, a parameterized n-bit shift register with load, shift-enable and serial-in/serial-out, honouring `SPI_LSB_FIRST_EN`. It is instantiated twice (tx, rx) or once as a combined register.
- `clk_div` is instantiated by the parent, not inside this block.

## Test plan
- Loopback: `miso_i`=`mosi_o`, `tick_i`≡1, send 0xA5 → `data_o`=0xA5; `done_o` pulses on cycle T19; exactly 8 SCLK rising edges.
- `miso_i` tied 1, send 0x3C, tick every 4 cycles → MOSI bits 0,0,1,1,1,1,0,0 at rising edges; `data_o`=0xFF; SCLK half-period = 4 cycles.
- `start_i` pulsed again at SCLK edge 5 of a transfer → ignored; a single `done_o`; `data_o` matches the first word only.
- Back-to-back: `start_i` held high, words 0x01 then 0x80 → two `done_o` pulses; `cs_o` high for exactly 1 cycle between words.
- Reset asserted after the 5th rising SCLK edge → same cycle `cs_o`=1, `sclk_o`=0, `busy_o`=0; no `done_o`; `data_o`=0.
- Built with `SPI_LSB_FIRST_EN`, send 0x01 in loopback → first MOSI bit is 1; `data_o`=0x01.
